// File: rtl/mem_arbiter_seq_if.sv
// mem_arbiter_seq_if: fetch/load-store request channels and byte-wide RAM port of the arbiter
interface mem_arbiter_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4,
  parameter int INST_BYTES = 4
);
  logic rdy_in;
  logic io_buffer_full;
  logic inst_req;
  logic inst_abort;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [8*INST_BYTES-1:0] inst_data;
  logic inst_done;
  logic data_req;
  logic data_we;
  logic [2:0] data_len;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [8*DATA_BYTES-1:0] data_wdata;
  logic [8*DATA_BYTES-1:0] data_rdata;
  logic data_done;
  logic ram_wr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0] ram_w_data;
  logic [7:0] ram_r_data;
  modport slave (
    input rdy_in, io_buffer_full, inst_req, inst_abort, inst_addr,
    input data_req, data_we, data_len, data_addr, data_wdata, ram_r_data,
    output inst_data, inst_done, data_rdata, data_done, ram_wr, ram_addr, ram_w_data
  );
  modport master (
    output rdy_in, io_buffer_full, inst_req, inst_abort, inst_addr,
    output data_req, data_we, data_len, data_addr, data_wdata, ram_r_data,
    input inst_data, inst_done, data_rdata, data_done, ram_wr, ram_addr, ram_w_data
  );
endinterface

// File: rtl/mem_arbiter_seq.sv
// mem_arbiter_seq: serialises fetch and load/store accesses onto one byte-wide synchronous RAM port
module mem_arbiter_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4,
  parameter int INST_BYTES = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE = ADDR_WIDTH'(32'h30000)
) (
  input logic clk_in,
  input logic rst_in,
  mem_arbiter_seq_if.slave bus
);
  localparam int MB = DATA_BYTES > INST_BYTES ? DATA_BYTES : INST_BYTES;
  localparam int KW = $clog2(MB + 1);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t st;
  logic inst_own;
  logic wr_q;
  logic stl;
  logic [KW-1:0] k;
  logic [KW-1:0] n;
  logic [7:0] stash;
  logic [7:0] rbyte;
  logic [8*MB-1:0] asm_q;
  logic [8*MB-1:0] asm_nx;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
    return a >= IO_BASE;
  endfunction
  // merge the byte arriving this cycle; a byte that landed just as the block froze is replayed from stash
  always_comb begin
    rbyte = stl ? stash : bus.ram_r_data;
    asm_nx = asm_q | ((8*MB)'(rbyte) << {k - KW'(1), 3'b000});
    nxt_addr = bus.ram_addr + ADDR_WIDTH'(1);
  end
  assign bus.ram_wr = wr_q & bus.rdy_in;
  // arbitration, byte sequencing and registered outputs; rdy_in low freezes everything
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st <= IDLE;
      inst_own <= 1'b0;
      wr_q <= 1'b0;
      stl <= 1'b0;
      k <= '0;
      n <= '0;
      stash <= '0;
      asm_q <= '0;
      bus.ram_addr <= '0;
      bus.ram_w_data <= '0;
      bus.inst_data <= '0;
      bus.data_rdata <= '0;
      bus.inst_done <= 1'b0;
      bus.data_done <= 1'b0;
    end else if (!bus.rdy_in) begin
      stl <= 1'b1;
      if (!stl) stash <= bus.ram_r_data;
    end else begin
      stl <= 1'b0;
      case (st)
        IDLE: begin
          k <= '0;
          asm_q <= '0;
          wr_q <= bus.data_req && bus.data_we && !(is_io(bus.data_addr) && bus.io_buffer_full);
          if (bus.data_req) begin
            st <= bus.data_we ? WR : RD;
            inst_own <= 1'b0;
            n <= KW'(bus.data_len);
            bus.ram_addr <= bus.data_addr;
            bus.ram_w_data <= bus.data_wdata[7:0];
          end else if (bus.inst_req && !bus.inst_abort) begin
            st <= RD;
            inst_own <= 1'b1;
            n <= KW'(INST_BYTES);
            bus.ram_addr <= bus.inst_addr;
          end
        end
        RD: begin
          if (inst_own && bus.inst_abort) begin
            st <= IDLE;
          end else begin
            if (k != '0) asm_q <= asm_nx;
            if (k == n) begin
              st <= DONE;
              if (inst_own) begin
                bus.inst_data <= asm_nx[8*INST_BYTES-1:0];
                bus.inst_done <= 1'b1;
              end else begin
                bus.data_rdata <= asm_nx[8*DATA_BYTES-1:0];
                bus.data_done <= 1'b1;
              end
            end else begin
              k <= k + KW'(1);
              if (k + KW'(1) != n) bus.ram_addr <= nxt_addr;
            end
          end
        end
        WR: begin
          if (!wr_q) begin
            wr_q <= !(is_io(bus.ram_addr) && bus.io_buffer_full);
          end else if (k == n - KW'(1)) begin
            st <= DONE;
            wr_q <= 1'b0;
            bus.data_done <= 1'b1;
          end else begin
            k <= k + KW'(1);
            bus.ram_addr <= nxt_addr;
            bus.ram_w_data <= bus.data_wdata[{k + KW'(1), 3'b000} +: 8];
            wr_q <= !(is_io(nxt_addr) && bus.io_buffer_full);
          end
        end
        default: begin
          st <= IDLE;
          bus.inst_done <= 1'b0;
          bus.data_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_seq.sv
// tb_mem_arbiter_seq: vector table plus corner-case sequences, scoreboarded against a reference memory
module tb_mem_arbiter_seq;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  bit load_mem = 1'b1;
  always #5 clk_in = ~clk_in;
  mem_arbiter_seq_if bus();
  mem_arbiter_seq dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
  typedef struct {bit inst; logic [31:0] data; bit chk;} done_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  typedef struct {string nm; bit inst; bit we; logic [2:0] len; logic [31:0] addr; logic [31:0] wdata; int lat;} vec_t;
  done_t dq[$];
  wr_t wq[$];
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
  int total = 0;
  int bad = 0;
  // synchronous RAM: data for an address appears the cycle after it
  always @(posedge clk_in) begin
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    end else begin
      bus.ram_r_data <= mem[bus.ram_addr[9:0]];
      if (bus.ram_wr) mem[bus.ram_addr[9:0]] <= bus.ram_w_data;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // completion scoreboard
  always @(negedge clk_in) begin
    if (bus.inst_done || bus.data_done) begin
      if (dq.size() == 0) begin
        chk("spurious_done", {30'd0, bus.inst_done, bus.data_done}, 32'd0);
      end else begin : pop_done
        done_t e;
        e = dq.pop_front();
        chk("done_chan", {30'd0, bus.inst_done, bus.data_done}, e.inst ? 32'd2 : 32'd1);
        if (e.chk) chk("done_data", e.inst ? bus.inst_data : bus.data_rdata, e.data);
      end
    end
  end
  // RAM write scoreboard
  always @(negedge clk_in) begin
    if (bus.ram_wr) begin
      if (wq.size() == 0) begin
        chk("spurious_wr", {31'd0, bus.ram_wr}, 32'd0);
      end else begin : pop_wr
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", bus.ram_addr, w.a);
        chk("wr_data", {24'd0, bus.ram_w_data}, {24'd0, w.d});
      end
    end
  end
  function automatic logic [31:0] model_rd(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[10'(a + 32'(i))];
    return r;
  endfunction
  task automatic expect_xfer(input bit inst, input bit we, input int len, input logic [31:0] addr, input logic [31:0] wdata);
    if (we) begin
      for (int i = 0; i < len; i++) begin
        wq.push_back('{a: addr + 32'(i), d: wdata[8*i +: 8]});
        ref_mem[10'(addr + 32'(i))] = wdata[8*i +: 8];
      end
      dq.push_back('{inst: 1'b0, data: 32'd0, chk: 1'b0});
    end else begin
      dq.push_back('{inst: inst, data: model_rd(addr, inst ? 4 : len), chk: 1'b1});
    end
  endtask
  task automatic drive(input bit inst, input bit we, input int len, input logic [31:0] addr, input logic [31:0] wdata);
    if (inst) begin
      bus.inst_req = 1'b1;
      bus.inst_addr = addr;
    end else begin
      bus.data_req = 1'b1;
      bus.data_we = we;
      bus.data_len = 3'(len);
      bus.data_addr = addr;
      bus.data_wdata = wdata;
    end
  endtask
  task automatic wait_done(input string nm, input int lat, input bit ac, input logic [31:0] a, input int n);
    bit got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk_in);
      if (ac && c <= n) chk($sformatf("%s_addr%0d", nm, c), bus.ram_addr, a + 32'(c - 1));
      if (bus.inst_done || bus.data_done) begin
        got = 1'b1;
        chk({nm, "_lat"}, 32'(c), 32'(lat));
      end
    end
    if (!got) chk({nm, "_timeout"}, {31'd0, got}, 32'd1);
  endtask
  task automatic run_xfer(input vec_t v);
    expect_xfer(v.inst, v.we, int'(v.len), v.addr, v.wdata);
    drive(v.inst, v.we, int'(v.len), v.addr, v.wdata);
    wait_done(v.nm, v.lat, !v.we, v.addr, v.inst ? 4 : int'(v.len));
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    @(negedge clk_in);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end
  initial begin
    vec_t tbl[9];
    tbl = '{
      '{"fetch100", 1'b1, 1'b0, 3'd4, 32'h100, 32'h0, 6},
      '{"ld1_10", 1'b0, 1'b0, 3'd1, 32'h10, 32'h0, 3},
      '{"ld2_20", 1'b0, 1'b0, 3'd2, 32'h20, 32'h0, 4},
      '{"st4_40", 1'b0, 1'b1, 3'd4, 32'h40, 32'hDEADBEEF, 5},
      '{"ld4_40", 1'b0, 1'b0, 3'd4, 32'h40, 32'h0, 6},
      '{"st2_50", 1'b0, 1'b1, 3'd2, 32'h50, 32'h1234, 3},
      '{"ld3_50", 1'b0, 1'b0, 3'd3, 32'h50, 32'h0, 5},
      '{"st2_wrap", 1'b0, 1'b1, 3'd2, 32'hFFFFFFFF, 32'hA55A, 3},
      '{"fetch_wrap", 1'b1, 1'b0, 3'd4, 32'hFFFFFFFE, 32'h0, 6}
    };
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);
    ref_mem[10'h100] = 8'h13;
    ref_mem[10'h101] = 8'h05;
    ref_mem[10'h102] = 8'h00;
    ref_mem[10'h103] = 8'h00;
    ref_mem[10'h020] = 8'hAA;
    ref_mem[10'h021] = 8'hBB;
    bus.rdy_in = 1'b1;
    bus.io_buffer_full = 1'b0;
    bus.inst_req = 1'b0;
    bus.inst_abort = 1'b0;
    bus.inst_addr = '0;
    bus.data_req = 1'b0;
    bus.data_we = 1'b0;
    bus.data_len = 3'd1;
    bus.data_addr = '0;
    bus.data_wdata = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_ram_addr", bus.ram_addr, 32'd0);
    chk("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("rst_w_data", {24'd0, bus.ram_w_data}, 32'd0);
    chk("rst_dones", {30'd0, bus.inst_done, bus.data_done}, 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'd0);
    chk("rst_rdata", bus.data_rdata, 32'd0);
    load_mem = 1'b0;
    rst_in = 1'b0;
    @(negedge clk_in);
    for (int i = 0; i < 9; i++) run_xfer(tbl[i]);
    // simultaneous requests: data first, fetch accepted from the IDLE cycle after DONE
    expect_xfer(1'b0, 1'b0, 2, 32'h20, 32'h0);
    expect_xfer(1'b1, 1'b0, 4, 32'h100, 32'h0);
    drive(1'b0, 1'b0, 2, 32'h20, 32'h0);
    drive(1'b1, 1'b0, 4, 32'h100, 32'h0);
    wait_done("sim_data", 4, 1'b1, 32'h20, 2);
    bus.data_req = 1'b0;
    wait_done("sim_inst", 7, 1'b0, 32'h0, 0);
    bus.inst_req = 1'b0;
    @(negedge clk_in);
    chk("sim_rdata", bus.data_rdata, 32'h0000BBAA);
    chk("sim_idata", bus.inst_data, 32'h00000513);
    // IO store held off by a full buffer for three cycles
    expect_xfer(1'b0, 1'b1, 1, 32'h30000, 32'h77);
    bus.io_buffer_full = 1'b1;
    drive(1'b0, 1'b1, 1, 32'h30000, 32'h77);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_in);
      chk($sformatf("io_stall%0d", c), {31'd0, bus.ram_wr}, 32'd0);
    end
    bus.io_buffer_full = 1'b0;
    @(negedge clk_in);
    chk("io_write", {31'd0, bus.ram_wr}, 32'd1);
    wait_done("io_done", 1, 1'b0, 32'h0, 0);
    bus.data_req = 1'b0;
    @(negedge clk_in);
    // fetch aborted at T+3, pending load accepted at T+4
    drive(1'b1, 1'b0, 4, 32'h100, 32'h0);
    @(negedge clk_in);
    expect_xfer(1'b0, 1'b0, 1, 32'h10, 32'h0);
    drive(1'b0, 1'b0, 1, 32'h10, 32'h0);
    @(negedge clk_in);
    @(negedge clk_in);
    bus.inst_abort = 1'b1;
    @(negedge clk_in);
    chk("abort_nodone", {31'd0, bus.inst_done}, 32'd0);
    bus.inst_abort = 1'b0;
    bus.inst_req = 1'b0;
    @(negedge clk_in);
    chk("abort_ld_addr", bus.ram_addr, 32'h10);
    wait_done("abort_ld", 2, 1'b0, 32'h0, 0);
    bus.data_req = 1'b0;
    @(negedge clk_in);
    // reset two bytes into a word store
    for (int i = 0; i < 2; i++) begin
      wq.push_back('{a: 32'h60 + 32'(i), d: i == 0 ? 8'hEF : 8'hBE});
      ref_mem[10'h60 + 10'(i)] = i == 0 ? 8'hEF : 8'hBE;
    end
    drive(1'b0, 1'b1, 4, 32'h60, 32'hDEADBEEF);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    bus.data_req = 1'b0;
    @(negedge clk_in);
    chk("mrst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("mrst_ram_addr", bus.ram_addr, 32'd0);
    chk("mrst_w_data", {24'd0, bus.ram_w_data}, 32'd0);
    chk("mrst_dones", {30'd0, bus.inst_done, bus.data_done}, 32'd0);
    chk("mrst_rdata", bus.data_rdata, 32'd0);
    rst_in = 1'b0;
    repeat (6) @(negedge clk_in);
    // rdy_in low for two cycles in the middle of a word load
    expect_xfer(1'b0, 1'b0, 4, 32'h40, 32'h0);
    drive(1'b0, 1'b0, 4, 32'h40, 32'h0);
    @(negedge clk_in);
    @(negedge clk_in);
    bus.rdy_in = 1'b0;
    @(negedge clk_in);
    chk("frz_addr", bus.ram_addr, 32'h41);
    @(negedge clk_in);
    bus.rdy_in = 1'b1;
    wait_done("frz_ld", 4, 1'b0, 32'h0, 0);
    bus.data_req = 1'b0;
    @(negedge clk_in);
    chk("frz_rdata", bus.data_rdata, 32'hDEADBEEF);
    repeat (3) @(negedge clk_in);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
